// File: rtl/stereo_frame_serializer_if.sv
// Handshake bundle for stereo_frame_serializer.
//   s_valid/s_ready/s_left/s_right : upstream stereo frame input
//   m_valid/m_ready/m_is_left/m_audio : channel word stream to the encoder
// modport slave  : serializer view
// modport master : environment view (frame source + encoder sink)
interface stereo_frame_serializer_if #(
  parameter int unsigned audio_width = 16
);
  logic                   s_valid;
  logic                   s_ready;
  logic [audio_width-1:0] s_left;
  logic [audio_width-1:0] s_right;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_is_left;
  logic [audio_width-1:0] m_audio;

  modport slave (
    input  s_valid, s_left, s_right, m_ready,
    output s_ready, m_valid, m_is_left, m_audio
  );

  modport master (
    output s_valid, s_left, s_right, m_ready,
    input  s_ready, m_valid, m_is_left, m_audio
  );
endinterface

// File: rtl/stereo_frame_serializer.sv
// Stereo frame serializer: buffers {left,right} frames in a circular FIFO and
// emits them as an interleaved word stream (left first) tagged by m_is_left.
// If the encoder reports underrun while the right word is pending, the head
// frame is dropped so the encoder and serializer realign on the next left word.
// Ports:
//   clk, reset_n     : clock, async active-low reset
//   flush            : sync clear of FIFO and phase (drop_count kept)
//   enc_underrun     : encoder underrun indication
//   bus (slave)      : s_* frame input, m_* word output
//   level            : frames stored, including the one being emitted
//   drop_count       : saturating count of realignment drops
module stereo_frame_serializer #(
  parameter int unsigned audio_width = 16,
  parameter int unsigned depth       = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     enc_underrun,
  stereo_frame_serializer_if.slave bus,
  output logic [$clog2(depth):0]   level,
  output logic [15:0]              drop_count
);
  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned LW = PW + 1;

  typedef enum logic {PH_LEFT = 1'b0, PH_RIGHT = 1'b1} phase_t;

  logic [audio_width-1:0] mem_l [depth];
  logic [audio_width-1:0] mem_r [depth];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level_q, level_d;
  logic                   s_ready_q;
  logic [15:0]            drop_q;
  phase_t                 phase_q, phase_d;

  logic empty, realign, xfer, push, pop;

  always_comb begin
    empty   = (level_q == '0);
    realign = (phase_q == PH_RIGHT) && enc_underrun && !empty;
    bus.m_valid   = !empty && !((phase_q == PH_RIGHT) && enc_underrun);
    bus.m_is_left = (phase_q == PH_LEFT);
    bus.m_audio   = '0;
    if (!empty)
      bus.m_audio = (phase_q == PH_LEFT) ? mem_l[rd_ptr] : mem_r[rd_ptr];
    xfer = bus.m_valid && bus.m_ready;
    push = bus.s_valid && s_ready_q && !flush;
    // Realign and transfer are mutually exclusive: m_valid is low whenever
    // a realign is pending.
    pop  = !flush && (realign || (xfer && (phase_q == PH_RIGHT)));
    level_d = flush ? '0 : (level_q + LW'(push) - LW'(pop));
  end

  always_comb begin
    phase_d = phase_q;
    if (flush || realign)
      phase_d = PH_LEFT;
    else if (xfer)
      phase_d = (phase_q == PH_LEFT) ? PH_RIGHT : PH_LEFT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      phase_q <= PH_LEFT;
    else
      phase_q <= phase_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b1;
      drop_q    <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level_q <= level_d;
      // Registered from the next level so s_ready never depends on m_ready
      // within the same cycle.
      s_ready_q <= (level_d < LW'(depth));
      if (realign && !flush && (drop_q != '1))
        drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= bus.s_left;
      mem_r[wr_ptr] <= bus.s_right;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign level       = level_q;
  assign drop_count  = drop_q;
endmodule

// File: tb/tb_stereo_frame_serializer.sv
// Scoreboard bench for stereo_frame_serializer. Accepted frames become two
// expected words in a queue; the monitor compares the presented word stream,
// level, s_ready and drop_count against that queue every cycle.
module tb_stereo_frame_serializer;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          enc_underrun;
  logic [2:0]    level;
  logic [15:0]   drop_count;

  stereo_frame_serializer_if #(.audio_width(AW)) bus();

  stereo_frame_serializer #(.audio_width(AW), .depth(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .enc_underrun (enc_underrun),
    .bus          (bus),
    .level        (level),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [AW-1:0] exp_q[$];
  logic [15:0]   exp_drop = '0;
  bit            accept_ok = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame acceptance: a frame offered while the model has room is expected.
  always @(posedge clk) begin
    if (reset_n && !flush && bus.s_valid && accept_ok) begin
      exp_q.push_back(bus.s_left);
      exp_q.push_back(bus.s_right);
    end
  end

  // Monitor: sample mid-cycle, compare, then retire what the next edge consumes.
  always @(negedge clk) begin : mon
    int unsigned sz, frames;
    bit mid, exp_valid;
    if (!reset_n) begin
      exp_q.delete();
      exp_drop  = '0;
      accept_ok = 1'b1;
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_is_left", 32'(bus.m_is_left), 32'd1);
      check("rst_audio",   32'(bus.m_audio), 32'd0);
      check("rst_level",   32'(level), 32'd0);
      check("rst_s_ready", 32'(bus.s_ready), 32'd1);
      check("rst_drops",   32'(drop_count), 32'd0);
    end else begin
      sz        = exp_q.size();
      mid       = (sz % 2) == 1;
      frames    = (sz + 1) / 2;
      exp_valid = (sz > 0) && !(mid && enc_underrun);
      check("level",      32'(level), frames);
      check("s_ready",    32'(bus.s_ready), 32'(frames < DEPTH));
      check("drop_count", 32'(drop_count), 32'(exp_drop));
      check("m_valid",    32'(bus.m_valid), 32'(exp_valid));
      check("m_is_left",  32'(bus.m_is_left), 32'(!mid));
      check("m_audio",    32'(bus.m_audio), (sz > 0) ? 32'(exp_q[0]) : 32'd0);
      accept_ok = frames < DEPTH;
      if (flush)
        exp_q.delete();
      else if (mid && enc_underrun) begin
        void'(exp_q.pop_front());
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      end else if (exp_valid && bus.m_ready)
        void'(exp_q.pop_front());
    end
  end

  task automatic step(input bit sv, input logic [AW-1:0] l, input logic [AW-1:0] r,
                      input bit mr, input bit ur, input bit fl);
    @(posedge clk);
    #1;
    bus.s_valid  = sv;
    bus.s_left   = l;
    bus.s_right  = r;
    bus.m_ready  = mr;
    enc_underrun = ur;
    flush        = fl;
  endtask

  task automatic idle(input bit mr, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, '0, '0, mr, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.s_valid = 0; bus.s_left = '0; bus.s_right = '0; bus.m_ready = 0;
    enc_underrun = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic interleave with encoder always ready.
    step(1, 16'h1111, 16'h2222, 1, 0, 0);
    step(1, 16'h3333, 16'h4444, 1, 0, 0);
    idle(1, 6);

    // Fill to full with encoder stalled, then one left and one right transfer.
    for (int unsigned i = 0; i < DEPTH; i++)
      step(1, AW'($urandom), AW'($urandom), 0, 0, 0);
    idle(0, 2);
    idle(1, 1);
    idle(0, 2);
    idle(1, 1);
    idle(0, 2);
    idle(1, 10);

    // Mid-frame underrun drops the stale right word.
    step(1, 16'hAAAA, 16'hBBBB, 0, 0, 0);
    step(1, 16'hCCCC, 16'hDDDD, 0, 0, 0);
    idle(1, 1);
    step(0, '0, '0, 1, 1, 0);
    idle(1, 4);

    // Underrun while expecting left on an empty FIFO is harmless.
    step(0, '0, '0, 0, 1, 0);
    step(1, 16'h5555, 16'h6666, 0, 1, 0);
    idle(0, 1);
    idle(1, 3);

    // Flush with a frame on offer.
    for (int unsigned i = 0; i < 3; i++)
      step(1, AW'($urandom), AW'($urandom), 0, 0, 0);
    step(1, 16'h7777, 16'h8888, 0, 0, 1);
    idle(1, 3);

    // Saturation: preload near the top, then keep realigning.
    step(0, '0, '0, 0, 0, 0);
    force dut.drop_q = 16'hFFFD;
    exp_drop = 16'hFFFD;
    #1 release dut.drop_q;
    for (int unsigned i = 0; i < 4; i++) begin
      step(1, AW'($urandom), AW'($urandom), 0, 0, 0);
      idle(1, 1);
      step(0, '0, '0, 1, 1, 0);
    end
    idle(1, 3);

    // Randomized traffic.
    for (int unsigned i = 0; i < 3000; i++)
      step($urandom_range(1, 0) == 1, AW'($urandom), AW'($urandom),
           $urandom_range(9, 0) < 6, $urandom_range(7, 0) == 0,
           $urandom_range(63, 0) == 0);
    idle(1, 10);

    // Asynchronous reset in the middle of a frame.
    step(1, 16'h9999, 16'hEEEE, 0, 0, 0);
    idle(1, 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_m_valid", 32'(bus.m_valid), 32'd0);
    check("async_is_left", 32'(bus.m_is_left), 32'd1);
    check("async_audio",   32'(bus.m_audio), 32'd0);
    check("async_level",   32'(level), 32'd0);
    check("async_s_ready", 32'(bus.s_ready), 32'd1);
    check("async_drops",   32'(drop_count), 32'd0);
    bus.m_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step(1, 16'h1234, 16'h5678, 1, 0, 0);
    idle(1, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
